// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad (1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D). One
// column is driven low at a time and the active-low rows are read back. Each
// full pass over the four columns produces a frame result. Frame results are
// debounced, and the committed key is presented as a code, a held flag and a
// one-cycle new-press strobe.
//
// Parameters:
//   SCAN_DIV        clock cycles each column stays driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical frame results needed to commit (>= 1)
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   row[3:0]   in   keypad rows, active-low (row[0] = 1 2 3 A, row[3] = 0 F E D)
//   col[3:0]   out  column drive, active-low, one bit low (col[0] = 1 4 7 0)
//   key_val    out  committed key code, 4'hF when no key is held
//   key_held   out  high while a committed key is held
//   key_valid  out  one-cycle pulse when a new key is committed
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_val,
    output logic       key_held,
    output logic       key_valid
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

    // Key code at a (column, row) crossing of the matrix.
    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // ---------------------------------------------------------------- state
    logic [3:0]        sync1_q, sync2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        idx_q, idx_d;
    logic              cand_none_q, cand_none_d;
    logic [3:0]        cand_code_q, cand_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_val_q, key_val_d;
    logic              key_held_q, key_held_d;
    logic              key_valid_q, key_valid_d;

    logic              slot_last;
    logic              frame_end;
    logic [3:0][3:0]   frame_rows;
    logic              res_none;
    logic [3:0]        res_code;

    assign slot_last = (slot_q == SLOT_LAST);
    assign frame_end = slot_last && (idx_q == 2'd3);

    // Per-column row samples for columns 0..2. Column 3 is evaluated straight
    // from the synchronizer on the same edge that would have captured it, so
    // it needs no storage of its own.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_col
            logic [3:0] samp_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    samp_q <= 4'hF;
                end else if (slot_last && (idx_q == 2'(gi))) begin
                    samp_q <= sync2_q;
                end
            end
        end
    endgenerate

    assign frame_rows = {sync2_q, gen_col[2].samp_q, gen_col[1].samp_q, gen_col[0].samp_q};

    // First asserted position in scan order. Iterating from the last position
    // back to the first lets the earliest hit overwrite any later one.
    always_comb begin
        res_none = 1'b1;
        res_code = 4'hF;
        for (int c = 3; c >= 0; c--) begin
            for (int r = 3; r >= 0; r--) begin
                if (!frame_rows[c][r]) begin
                    res_none = 1'b0;
                    res_code = key_code(2'(c), 2'(r));
                end
            end
        end
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        logic same;
        logic differs;

        slot_d      = slot_last ? '0 : slot_q + 1'b1;
        idx_d       = slot_last ? idx_q + 2'd1 : idx_q;
        cand_none_d = cand_none_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        key_val_d   = key_val_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        same        = 1'b0;
        differs     = 1'b0;

        if (frame_end) begin
            same = (res_none == cand_none_q) && (res_none || (res_code == cand_code_q));
            if (same) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_none_d = res_none;
                cand_code_d = res_code;
                cnt_d       = CNT_W'(1);
            end

            // Committed "none" is represented by key_held low.
            if (cand_none_d) begin
                differs = key_held_q;
            end else begin
                differs = !key_held_q || (key_val_q != cand_code_d);
            end

            if ((cnt_d == CNT_MAX) && differs) begin
                if (cand_none_d) begin
                    key_val_d  = 4'hF;
                    key_held_d = 1'b0;
                end else begin
                    key_val_d   = cand_code_d;
                    key_held_d  = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            slot_q      <= '0;
            idx_q       <= 2'd0;
            cand_none_q <= 1'b1;
            cand_code_q <= 4'hF;
            cnt_q       <= '0;
            key_val_q   <= 4'hF;
            key_held_q  <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            sync1_q     <= row;
            sync2_q     <= sync1_q;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            cand_none_q <= cand_none_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            key_val_q   <= key_val_d;
            key_held_q  <= key_held_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = ~(4'b0001 << idx_q);
    assign key_val   = key_val_q;
    assign key_held  = key_held_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_val;
    logic       key_held;
    logic       key_valid;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_val   (key_val),
        .key_held  (key_held),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Key code at matrix position p = column*4 + row; position order is scan order.
    int kmap [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    // Pressed keys, indexed by matrix position.
    logic [15:0] pressed = '0;

    // Keypad model: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of frame results (-1 = none) and committed state.
    int         hist [$];
    logic [3:0] m_val  = 4'hF;
    logic       m_held = 1'b0;

    function automatic logic [15:0] kbit(input int code);
        logic [15:0] m;
        m = '0;
        for (int p = 0; p < 16; p++) begin
            if (kmap[p] == code) m = 16'(1) << p;
        end
        return m;
    endfunction

    function automatic int first_key(input logic [15:0] keys);
        for (int p = 0; p < 16; p++) begin
            if (keys[p]) return kmap[p];
        end
        return -1;
    endfunction

    // Run one full frame with the given key set; called at cycle 0 of a frame
    // (just after a negedge) and returns at cycle 0 of the next frame.
    task automatic run_frame(input logic [15:0] keys, input string tag);
        int         pulses;
        int         res;
        logic       exp_pulse;
        logic       all_eq;
        logic [3:0] exp_col;
        pressed = keys;
        pulses  = 0;
        for (int i = 0; i < FRAME; i++) begin
            exp_col = 4'hF;
            exp_col[i / SD] = 1'b0;
            n_cmp++;
            if (col !== exp_col) begin
                n_bad++;
                $display("FAIL col_%s cycle %0d: got %b want %b", tag, i, col, exp_col);
            end
            if (i > 0 && key_valid === 1'b1) pulses++;
            @(negedge clk);
        end

        res = first_key(keys);
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        exp_pulse = 1'b0;
        all_eq = (hist.size() == DEB);
        foreach (hist[k]) if (hist[k] != res) all_eq = 1'b0;
        if (all_eq) begin
            if (res < 0) begin
                m_held = 1'b0;
                m_val  = 4'hF;
            end else if (!m_held || m_val != 4'(res)) begin
                m_held    = 1'b1;
                m_val     = 4'(res);
                exp_pulse = 1'b1;
            end
        end

        $display("frame %-8s keys=%04h result=%0d key_val=%h key_held=%b key_valid=%b",
                 tag, keys, res, key_val, key_held, key_valid);
        n_cmp++;
        if (key_val !== m_val) begin
            n_bad++;
            $display("FAIL key_val_%s: got %h want %h", tag, key_val, m_val);
        end
        n_cmp++;
        if (key_held !== m_held) begin
            n_bad++;
            $display("FAIL key_held_%s: got %b want %b", tag, key_held, m_held);
        end
        n_cmp++;
        if (key_valid !== exp_pulse) begin
            n_bad++;
            $display("FAIL key_valid_%s: got %b want %b", tag, key_valid, exp_pulse);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL stray_pulse_%s: got %0d want 0", tag, pulses);
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_cmp++;
        if (col !== 4'b1110) begin
            n_bad++;
            $display("FAIL %s_col: got %b want 1110", tag, col);
        end
        n_cmp++;
        if (key_val !== 4'hF || key_held !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_outputs: got val=%h held=%b valid=%b want val=f held=0 valid=0",
                     tag, key_val, key_held, key_valid);
        end
        $display("reset %s col=%b key_val=%h key_held=%b key_valid=%b",
                 tag, col, key_val, key_held, key_valid);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        check_reset_state("initial");
        reset = 1'b0;
        hist.delete();
        m_val  = 4'hF;
        m_held = 1'b0;
        run_frame('0, "idle");
        run_frame('0, "idle");
    endtask

    task automatic test_press_hold();
        for (int f = 0; f < 7; f++) run_frame(kbit(5), "hold5");
    endtask

    task automatic test_release_f();
        run_frame('0, "rel");
        run_frame('0, "rel");
        run_frame(kbit(15), "keyF");
        run_frame(kbit(15), "keyF");
        run_frame(kbit(15), "keyF");
    endtask

    task automatic test_bounce();
        run_frame('0, "rel");
        run_frame('0, "rel");
        for (int f = 0; f < 10; f++) run_frame((f % 2 == 0) ? kbit(9) : 16'h0, "bounce");
        run_frame(kbit(9), "steady9");
        run_frame(kbit(9), "steady9");
    endtask

    task automatic test_key_to_key();
        run_frame(kbit(1) | kbit(13), "k1andD");
        run_frame(kbit(1) | kbit(13), "k1andD");
        run_frame(kbit(13), "kD");
        run_frame(kbit(13), "kD");
        run_frame(kbit(13), "kD");
    endtask

    task automatic test_reset_midframe();
        run_frame(kbit(7), "hold7");
        pressed = kbit(7);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midframe");
        reset = 1'b0;
        hist.delete();
        m_val  = 4'hF;
        m_held = 1'b0;
        run_frame(kbit(7), "post_rst");
        run_frame(kbit(7), "post_rst");
        run_frame(kbit(7), "post_rst");
    endtask

    task automatic test_random();
        int          frames;
        int          choice;
        int          hold;
        logic [15:0] keys;
        frames = 0;
        while (frames < 40) begin
            choice = $urandom_range(0, 2);
            keys   = '0;
            if (choice >= 1) keys |= kbit($urandom_range(0, 15));
            if (choice == 2) keys |= kbit($urandom_range(0, 15));
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                run_frame(keys, "random");
                frames++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_press_hold();
        test_release_f();
        test_bounce();
        test_key_to_key();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D) by driving one column low at a time and reading the active-low rows. It debounces the result over whole scan frames. It presents the committed key as a 4-bit code, a held flag and a one-cycle new-press strobe. The block sits between the keypad header and `DisplayController`: `key_val` feeds `DispVal`, and `key_valid` is the per-press event consumed by digit-entry logic.

## Interface
- `SCAN_DIV`, 100000: clock cycles each column stays driven (1 ms at 100 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4: number of consecutive identical frame results required to commit; minimum 1.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, external pull-ups. `row[0]` = 1 2 3 A, `row[3]` = 0 F E D.
- `col`  out  4  column drive, active-low, exactly one bit low. `col[0]` = 1 4 7 0, `col[3]` = A B C D.
- `key_val`  out  4  committed key code: digits 0-9 as-is, A-F as 4'hA-4'hF; 4'hF when no key is held.
- `key_held`  out  1  high while a committed key is held. Distinguishes the F key (`key_val`=F, `key_held`=1) from no key.
- `key_valid`  out  1  one-cycle pulse when a new key is committed.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - Slot counter counts 0..SCAN_DIV-1; column index counts 0..3.
  - `col` = ~(1 << index).
  - On the slot's last cycle (count = SCAN_DIV-1), the synchronized rows are sampled into a per-column register. The index then advances, wrapping 3→0.
- Frame evaluation (at the last cycle of column 3):
  - The frame result is the first asserted position in scan order: column 0 before 3, then row 0 before 3 within a column.
  - Result is "none" if no row is low in any column.
  - With multiple keys held, the first in scan order wins. Example: 1 and D held → 1.
- Debounce:
  - Keeps a candidate register and a stable count (saturates at DEBOUNCE_SCANS).
  - Frame result equal to candidate → count+1.
  - Frame result different → candidate = result, count = 1.
- Commit: occurs when the updated count equals DEBOUNCE_SCANS and the candidate differs from the committed state.
  - Candidate is a key: `key_val` = code, `key_held` = 1, `key_valid` pulses.
  - Candidate is none: `key_val` = F, `key_held` = 0, no pulse.
- Key-to-key without an intervening committed none: commits the new key and pulses.
- Same key held indefinitely: no further pulses.
- Re-pressing the same key pulses only after none was committed in between.

## Timing
- Reset values:
  - `col` = 4'b1110, slot = 0, index = 0.
  - `key_val` = 4'hF, `key_held` = 0, `key_valid` = 0.
  - Candidate = none, count = 0, synchronizer and sample registers all-ones.
- Reset asserted mid-operation: all of the above take effect at the next edge. A partial debounce is discarded and no pulse is emitted.
- Frame length is 4·SCAN_DIV cycles. Column k is low during frame cycles k·SCAN_DIV .. (k+1)·SCAN_DIV-1.
- A row level must be present at the pins at least 2 cycles before the sampling edge to be captured.
- Outputs register at the frame-end edge. `key_valid` is high for exactly the one cycle after that edge.
- Commit latency from a clean press to the first frame that sees it: DEBOUNCE_SCANS frames. The release latency is the same.
- Counter widths: slot ≥ clog2(SCAN_DIV); debounce count ≥ clog2(DEBOUNCE_SCANS+1). No overflow is allowed; the count saturates.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 16 cycles).
- Reset, `row`=4'hF → `col` cycles 1110, 1101, 1011, 0111, 4 cycles each, repeating. `key_val`=F, `key_held`=0, `key_valid`=0 throughout.
- Hold key 5 (`row[1]` low whenever `col[1]` low) from frame start → after 2 frames: `key_val`=5, `key_held`=1, exactly one `key_valid` pulse. Holding 5 more frames gives no more pulses.
- Release 5 → after 2 none frames: `key_held`=0, `key_val`=F, no pulse. Press F (`row[3]` & `col[1]`) → `key_val`=F, `key_held`=1, one pulse.
- Bounce: key 9 present in alternate frames for 10 frames → no commit, no pulse. Then steady 9 for 2 frames → `key_val`=9, one pulse.
- Hold 1 and D together → `key_val`=1. Drop 1 while keeping D → after 2 frames `key_val`=D, one pulse (key-to-key).
- Hold 7 for 1 frame, assert `reset` for 1 cycle → `col`=1110 next cycle. With 7 still held, the commit occurs only after 2 further full frames, with a single pulse.
